// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file.
// Holds the clear-sequencer state enum and select-width function.
package rf_pkg;

  typedef enum logic [0:0] {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  function automatic int sel_w(input int regsize);
    return (regsize > 1) ? $clog2(regsize) : 1;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sweep sequencer: walks ptr 0..REGSIZE-1, one register per cycle.
// Ports: clk, rst, clear_req in; busy, clear_done, clr_en, clr_idx out.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int REGSIZE = 32,
  parameter int SEL_W   = sel_w(REGSIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_req,
  output logic             busy,
  output logic             clear_done,
  output logic             clr_en,
  output logic [SEL_W-1:0] clr_idx
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(REGSIZE - 1);

  rf_state_t        state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    busy       = 1'b0;
    clear_done = 1'b0;
    clr_en     = 1'b0;
    clr_idx    = ptr;
    unique case (state)
      RF_IDLE: begin
        if (clear_req) begin
          state_n = RF_CLEAR;
          ptr_n   = '0;
        end
      end
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        ptr_n  = ptr + SEL_W'(1);
        if (ptr == LAST) begin
          clear_done = 1'b1;
          state_n    = RF_IDLE;
          ptr_n      = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/multiport_register_file.sv
// Register file, NUM_RD comb reads, NUM_WR sync writes, hardwired zero reg, clear sweep.
// Ports: clk, rst, rd_sel/rd_data, wr_en/wr_sel/wr_data, clear_req, busy, clear_done.
// Option: define WRITE_BYPASS_EN to forward same-cycle write data to matching reads.
module multiport_register_file
  import rf_pkg::*;
#(
  parameter  int BITSIZE  = 64,
  parameter  int REGSIZE  = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 31,
  localparam int SEL_W    = sel_w(REGSIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*SEL_W-1:0]   rd_sel,
  output logic [NUM_RD*BITSIZE-1:0] rd_data,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*SEL_W-1:0]   wr_sel,
  input  logic [NUM_WR*BITSIZE-1:0] wr_data,
  input  logic                      clear_req,
  output logic                      busy,
  output logic                      clear_done
);

  localparam logic [SEL_W:0]   LIM  = SEL_W'(REGSIZE) == '0 ?
                                      (SEL_W+1)'(REGSIZE) : (SEL_W+1)'(REGSIZE);
  localparam logic [SEL_W-1:0] ZSEL = SEL_W'(ZERO_REG);

  logic [BITSIZE-1:0] regs [REGSIZE];
  logic               clr_en;
  logic [SEL_W-1:0]   clr_idx;

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < LIM) && (s != ZSEL);
  endfunction

  rf_clear_seq #(
    .REGSIZE (REGSIZE),
    .SEL_W   (SEL_W)
  ) u_clr (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx)
  );

  // Later ports overwrite earlier ones: highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGSIZE; i++) regs[i] <= '0;
    end else if (clr_en) begin
      regs[clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && sel_ok(wr_sel[w*SEL_W +: SEL_W]))
          regs[wr_sel[w*SEL_W +: SEL_W]] <= wr_data[w*BITSIZE +: BITSIZE];
      end
    end
  end

  always_comb begin
    logic [SEL_W-1:0] rs;
    rs      = '0;
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rs = rd_sel[p*SEL_W +: SEL_W];
      if (sel_ok(rs)) rd_data[p*BITSIZE +: BITSIZE] = regs[rs];
`ifdef WRITE_BYPASS_EN
      if (!busy && sel_ok(rs)) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_sel[w*SEL_W +: SEL_W] == rs))
            rd_data[p*BITSIZE +: BITSIZE] = wr_data[w*BITSIZE +: BITSIZE];
        end
      end
`endif
    end
  end

endmodule
